inst_mem_responder: RTL

Responder side of the instruction-fetch interface. It accepts the fetch PC and stall from the pipeline front end and returns the instruction word plus a 2-bit status after a configurable latency. Word storage is internal and is filled through a loader write port. It replaces the zero-latency instruction store so that the fetch stage's memory-stall path is exercised.

---
 rtl/inst_mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: returns the word at the fetch PC with a 2-bit status
// after a fixed latency; the word store is filled through a loader write port.
module inst_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        stall,
  input  logic        w_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic [1:0]  r_data_status,
  output logic [31:0] fetch_count
);

  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    VALID = 2'b10,
    ERR   = 2'b11
  } state_t;

  state_t      state;
  logic [31:0] tag;
  logic        tag_valid;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  // Misaligned, below the base, or past the end of the store.
  function automatic logic is_legal(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ((off >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] to_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  logic          a_legal;
  logic          w_legal;
  logic          w_hit_tag;
  logic          new_req;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] t_idx;
  logic [31:0]   a_word;
  logic [31:0]   t_word;

  // Store reads are write-first: a same-edge loader write to the word wins.
  always_comb begin
    a_legal   = is_legal(addr);
    w_legal   = w_en && is_legal(w_addr);
    a_idx     = to_idx(addr);
    w_idx     = to_idx(w_addr);
    t_idx     = to_idx(tag);
    w_hit_tag = w_legal && tag_valid && (w_addr == tag);
    new_req   = !tag_valid || (addr != tag);
    a_word    = (w_legal && (w_idx == a_idx)) ? w_data : mem[a_idx];
    t_word    = (w_legal && (w_idx == t_idx)) ? w_data : mem[t_idx];
  end

  // Word store is deliberately not reset; it survives rst.
  always_ff @(posedge clk) begin
    if (w_legal) mem[w_idx] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tag         <= '0;
      tag_valid   <= 1'b0;
      cnt         <= '0;
      r_data      <= '0;
      fetch_count <= '0;
    end else begin
      // Keeps a delivered word coherent with the store, even while stalled.
      if (state == VALID && w_hit_tag) r_data <= w_data;

      if (!stall) begin
        if (new_req) begin
          tag       <= addr;
          tag_valid <= 1'b1;
          if (!a_legal) begin
            state  <= ERR;
            r_data <= '0;
            cnt    <= '0;
          end else if (LATENCY == 1) begin
            state       <= VALID;
            r_data      <= a_word;
            cnt         <= '0;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            state <= BUSY;
            cnt   <= LAT_M1;
          end
        end else if (state == BUSY) begin
          if (cnt == 4'd1) begin
            state       <= VALID;
            r_data      <= t_word;
            cnt         <= '0;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      end
    end
  end

  assign r_data_status = state;

endmodule
